// File: rtl/ysyx_2022040010_div.sv
// Iterative radix-2 restoring divider for the RV64 M-extension divide/remainder ops.
// Handshake: accept on div_valid & div_ready, one-cycle div_over pulse with a held result.
module ysyx_2022040010_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            ret,
  input  logic            div_valid,
  input  logic            div_flush,
  input  logic            div_signed,
  input  logic            div_32,
  input  logic            sel_div_qr,
  input  logic [XLEN-1:0] ina,
  input  logic [XLEN-1:0] inb,
  output logic            div_ready,
  output logic            div_over,
  output logic [XLEN-1:0] div_result
);
  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, SPECIAL} state_t;

  state_t              state;
  logic [6:0]          cnt;
  logic [2*XLEN-1:0]   rq;       // {remainder, quotient} shift register
  logic [XLEN-1:0]     dvs;
  logic                q_sign;
  logic                r_sign;
  logic                sel_qr;
  logic                w32;

  logic [XLEN-1:0]     a_ext, b_ext, a_abs, b_abs, min_val;
  logic                a_neg, b_neg, b_zero, ovf;
  logic [2*XLEN-1:0]   sh;
  logic [XLEN:0]       diff;
  logic [2*XLEN-1:0]   iter_next;
  logic [XLEN-1:0]     q_fix, r_fix, pick, fin;
  logic [6:0]          n_last;

  // Operand preparation from the live inputs, used only on the acceptance edge.
  always_comb begin
    a_ext = ina;
    b_ext = inb;
    if (div_32) begin
      a_ext = div_signed ? {{HALF{ina[HALF-1]}}, ina[HALF-1:0]} : {{HALF{1'b0}}, ina[HALF-1:0]};
      b_ext = div_signed ? {{HALF{inb[HALF-1]}}, inb[HALF-1:0]} : {{HALF{1'b0}}, inb[HALF-1:0]};
    end
    a_neg   = div_signed & a_ext[XLEN-1];
    b_neg   = div_signed & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_val = div_32 ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = div_signed & (a_ext == min_val) & (&b_ext);
  end

  // One restoring step; the 65-bit trial keeps the bit shifted out of the remainder.
  always_comb begin
    sh        = {rq[2*XLEN-2:0], 1'b0};
    diff      = {rq[2*XLEN-1], sh[2*XLEN-1:XLEN]} - {1'b0, dvs};
    iter_next = diff[XLEN] ? sh : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
  end

  always_comb begin
    q_fix  = q_sign ? -rq[XLEN-1:0] : rq[XLEN-1:0];
    r_fix  = r_sign ? -rq[2*XLEN-1:XLEN] : rq[2*XLEN-1:XLEN];
    pick   = sel_qr ? r_fix : q_fix;
    fin    = w32 ? {{HALF{pick[HALF-1]}}, pick[HALF-1:0]} : pick;
    n_last = w32 ? 7'(HALF) : 7'(XLEN);
  end

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      state      <= IDLE;
      cnt        <= '0;
      rq         <= '0;
      dvs        <= '0;
      q_sign     <= 1'b0;
      r_sign     <= 1'b0;
      sel_qr     <= 1'b0;
      w32        <= 1'b0;
      div_ready  <= 1'b1;
      div_over   <= 1'b0;
      div_result <= '0;
    end else if (div_flush) begin
      state     <= IDLE;
      cnt       <= '0;
      div_ready <= 1'b1;
      div_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_over  <= 1'b0;
          div_ready <= 1'b1;
          if (div_valid && div_ready) begin
            div_ready <= 1'b0;
            sel_qr    <= sel_div_qr;
            w32       <= div_32;
            dvs       <= b_abs;
            cnt       <= '0;
            if (b_zero || ovf) begin
              // Special results are parked in rq so SPECIAL shares the output path with FIX.
              state  <= SPECIAL;
              q_sign <= 1'b0;
              r_sign <= 1'b0;
              rq     <= b_zero ? {a_ext, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_ext};
            end else begin
              state  <= CALC;
              q_sign <= a_neg ^ b_neg;
              r_sign <= a_neg;
              rq     <= div_32 ? {{XLEN{1'b0}}, a_abs[HALF-1:0], {HALF{1'b0}}}
                               : {{XLEN{1'b0}}, a_abs};
            end
          end
        end
        CALC: begin
          // N iterations, then one drain cycle before the correction step.
          if (cnt == n_last) begin
            state <= FIX;
          end else begin
            rq  <= iter_next;
            cnt <= cnt + 7'd1;
          end
        end
        FIX, SPECIAL: begin
          div_result <= fin;
          div_over   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Self-checking bench for ysyx_2022040010_div: directed vectors, random ops against an
// arithmetic reference model, flush and asynchronous reset in mid-operation.
module tb_ysyx_2022040010_div;
  logic        clk = 1'b0;
  logic        ret = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_flush = 1'b0;
  logic        div_signed = 1'b0;
  logic        div_32 = 1'b0;
  logic        sel_div_qr = 1'b0;
  logic [63:0] ina = '0;
  logic [63:0] inb = '0;
  logic        div_ready;
  logic        div_over;
  logic [63:0] div_result;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_result = '0;

  ysyx_2022040010_div #(.XLEN(64)) dut (
    .clk(clk), .ret(ret), .div_valid(div_valid), .div_flush(div_flush),
    .div_signed(div_signed), .div_32(div_32), .sel_div_qr(sel_div_qr),
    .ina(ina), .inb(inb), .div_ready(div_ready), .div_over(div_over),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    bit          w;
    bit          q;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // Reference model: RISC-V divide semantics using native arithmetic.
  function automatic logic [63:0] ref_model(bit s, bit w, bit q, logic [63:0] a, logic [63:0] b);
    logic [63:0] res;
    if (w) begin
      logic [31:0] r32;
      if (s) begin
        int sa, sb;
        sa = int'(a[31:0]);
        sb = int'(b[31:0]);
        if (sb == 0)                            r32 = q ? sa : 32'hFFFF_FFFF;
        else if (sa == 32'h8000_0000 && sb == -1) r32 = q ? 32'd0 : sa;
        else                                    r32 = q ? sa % sb : sa / sb;
      end else begin
        logic [31:0] ua, ub;
        ua = a[31:0];
        ub = b[31:0];
        if (ub == 0) r32 = q ? ua : 32'hFFFF_FFFF;
        else         r32 = q ? ua % ub : ua / ub;
      end
      res = {{32{r32[31]}}, r32};
    end else begin
      if (s) begin
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sb == 0)                                       res = q ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (a == 64'h8000_0000_0000_0000 && sb == -1) res = q ? 64'd0 : a;
        else                                               res = q ? 64'(sa % sb) : 64'(sa / sb);
      end else begin
        if (b == 0) res = q ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else        res = q ? a % b : a / b;
      end
    end
    return res;
  endfunction

  function automatic int ref_latency(bit s, bit w, logic [63:0] a, logic [63:0] b);
    bit special;
    if (w) special = (b[31:0] == 0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   special = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    return special ? 1 : (w ? 34 : 66);
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = {32'($urandom()), 32'h8000_0000};
      4:       v = 64'($urandom_range(1, 50));
      5:       v = {32'($urandom()), 32'($urandom_range(0, 1000))};
      default: v = {32'($urandom()), 32'($urandom())};
    endcase
    return v;
  endfunction

  // Drives one operation and reports the result, latency (-1 on timeout) and div_ready after acceptance.
  task automatic do_op(input bit s, input bit w, input bit q, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat,
                       output logic rdy_after);
    int k;
    k = 0;
    lat = -1;
    @(negedge clk);
    while (!div_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    div_signed = s;
    div_32     = w;
    sel_div_qr = q;
    ina        = a;
    inb        = b;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    rdy_after = div_ready;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (div_over) begin
        lat = c;
        break;
      end
    end
    res = div_result;
    $display("op s=%0d w=%0d rem=%0d a=%h b=%h -> res=%h lat=%0d", s, w, q, a, b, res, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", div_ready); end
    checks++;
    if (div_over !== 1'b0) begin errors++; $display("FAIL reset_over got=%b want=0", div_over); end
    checks++;
    if (div_result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", div_result); end
    @(negedge clk);
    ret = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs[11];
    logic [63:0] res;
    int lat;
    logic rdy;
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 66};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 66};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 64'h1234, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 64'hABCD_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].s, vecs[i].w, vecs[i].q, vecs[i].a, vecs[i].b, res, lat, rdy);
      checks++;
      if (res !== vecs[i].exp) begin
        errors++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, vecs[i].exp);
      end
      checks++;
      if (lat !== vecs[i].lat) begin
        errors++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, vecs[i].lat);
      end
      checks++;
      if (rdy !== 1'b0) begin
        errors++; $display("FAIL directed_busy[%0d] ready got=%b want=0", i, rdy);
      end
      last_result = vecs[i].exp;
    end
  endtask

  task automatic test_over_pulse();
    logic [63:0] res;
    int lat;
    logic rdy;
    do_op(1'b0, 1'b0, 1'b0, 64'd55, 64'd5, res, lat, rdy);
    last_result = 64'd11;
    checks++;
    if (res !== 64'd11) begin errors++; $display("FAIL pulse_result got=%h want=%h", res, 64'd11); end
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL pulse_ready_during_over got=%b want=0", div_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (div_over !== 1'b0) begin errors++; $display("FAIL pulse_over_width got=%b want=0", div_over); end
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL pulse_ready_after got=%b want=1", div_ready); end
    checks++;
    if (div_result !== 64'd11) begin errors++; $display("FAIL pulse_result_held got=%h want=%h", div_result, 64'd11); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res, exp;
    int lat, exp_lat;
    logic rdy;
    bit s, w, q;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      exp = ref_model(s, w, q, a, b);
      exp_lat = ref_latency(s, w, a, b);
      do_op(s, w, q, a, b, res, lat, rdy);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL random_result[%0d] s=%0d w=%0d rem=%0d a=%h b=%h got=%h want=%h", i, s, w, q, a, b, res, exp);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL random_latency[%0d] got=%0d want=%0d", i, lat, exp_lat);
      end
      last_result = exp;
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat;
    logic rdy;
    bit seen_over;
    @(negedge clk);
    div_signed = 1'b1; div_32 = 1'b0; sel_div_qr = 1'b0;
    ina = 64'd1000; inb = 64'd3; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    div_flush = 1'b1;
    div_valid = 1'b1;
    ina = 64'd77; inb = 64'd7;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    div_valid = 1'b0;
    $display("flush issued mid-operation");
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b want=1", div_ready); end
    checks++;
    if (div_over !== 1'b0) begin errors++; $display("FAIL flush_over got=%b want=0", div_over); end
    checks++;
    if (div_result !== last_result) begin errors++; $display("FAIL flush_result got=%h want=%h", div_result, last_result); end
    seen_over = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (div_over) seen_over = 1'b1;
    end
    checks++;
    if (seen_over !== 1'b0) begin errors++; $display("FAIL flush_no_over got=%b want=0", seen_over); end
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL flush_valid_ignored ready got=%b want=1", div_ready); end
    do_op(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, res, lat, rdy);
    checks++;
    if (res !== 64'd3) begin errors++; $display("FAIL flush_next_result got=%h want=%h", res, 64'd3); end
    checks++;
    if (lat !== 66) begin errors++; $display("FAIL flush_next_latency got=%0d want=66", lat); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    logic rdy;
    @(negedge clk);
    div_signed = 1'b0; div_32 = 1'b0; sel_div_qr = 1'b0;
    ina = 64'd5000; inb = 64'd9; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    ret = 1'b0;
    #1;
    $display("reset pulsed mid-operation");
    checks++;
    if (div_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", div_ready); end
    checks++;
    if (div_over !== 1'b0) begin errors++; $display("FAIL rstmid_over got=%b want=0", div_over); end
    checks++;
    if (div_result !== 64'd0) begin errors++; $display("FAIL rstmid_result got=%h want=0", div_result); end
    @(negedge clk);
    ret = 1'b1;
    do_op(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, res, lat, rdy);
    checks++;
    if (res !== 64'd3) begin errors++; $display("FAIL rstmid_next_result got=%h want=%h", res, 64'd3); end
    checks++;
    if (lat !== 66) begin errors++; $display("FAIL rstmid_next_latency got=%0d want=66", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_over_pulse();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
